mdio_phy_responder: RTL and testbench

- MDIO management slave (Clause 22): the PHY-side responder to the team's `mdio` master.
- Oversamples MDC/MDIO on `sys_clk` and decodes read and write frames addressed to `PHY_ADDR`.
- Holds a 32 x 16 register bank: writes update it, reads drive its contents back onto MDIO.
- Used as the bench-side PHY model for `mdio` and as a reusable soft-PHY register block.

---
 rtl/mdio_phy_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder
// Clause 22 MDIO management slave. MDC and MDIO are oversampled on sys_clk.
// The responder decodes read and write frames addressed to PHY_ADDR and
// serves a 32 x 16 register bank.
//
// Ports:
//   sys_clk, sys_rst_n   system clock, asynchronous active-low reset
//   mdc, mdio_in         management clock and pad-level MDIO (both async)
//   mdio_o, mdio_en      MDIO drive value and output enable (1 = drive)
//   reg_wr_en            one-cycle strobe when a register write commits
//   reg_wr_addr/data     address/data of that write, held until the next one
//   frame_err            one-cycle strobe on a write-frame turnaround error
//   fsm_state            current decoder state, for debug/checkers
//
// Handshake: reg_wr_en and frame_err are fire-and-forget strobes with no
// ready/backpressure; reg_wr_addr/reg_wr_data are valid in the strobe cycle.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter int          PREAMBLE_LEN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h0022,
  parameter logic [15:0] PHY_ID2      = 16'h1622
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_o,
  output logic        mdio_en,
  output logic        reg_wr_en,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        frame_err,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ST    = 3'd1,
    OP    = 3'd2,
    PHYAD = 3'd3,
    REGAD = 3'd4,
    TA    = 3'd5,
    WDATA = 3'd6,
    RDATA = 3'd7
  } state_t;

  localparam int CW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [CW-1:0] PRE_MAX = CW'(PREAMBLE_LEN);

  // Synchronisers; mdc_s3 is the previous synchronised mdc for edge detect.
  logic mdc_s1, mdc_s2, mdc_s3;
  logic mdio_s1, mdio_s;
  logic mdc_rise;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mdc_s1  <= 1'b0;
      mdc_s2  <= 1'b0;
      mdc_s3  <= 1'b0;
      mdio_s1 <= 1'b0;
      mdio_s  <= 1'b0;
    end else begin
      mdc_s1  <= mdc;
      mdc_s2  <= mdc_s1;
      mdc_s3  <= mdc_s2;
      mdio_s1 <= mdio_in;
      mdio_s  <= mdio_s1;
    end
  end

  assign mdc_rise = mdc_s2 & ~mdc_s3;

  state_t          state;
  logic [CW-1:0]   pre_cnt;
  logic [3:0]      bit_cnt;
  logic            op_msb;
  logic            is_read;
  logic [4:0]      phyad;
  logic [4:0]      regad;
  // Shared shift register: read data snapshot at end of REGAD, or write
  // data being assembled during WDATA.
  logic [15:0]     shreg;
  logic [15:0]     bank [32];
  logic [15:0]     wr_word;

  assign wr_word   = {shreg[14:0], mdio_s};
  assign fsm_state = state;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      pre_cnt     <= '0;
      bit_cnt     <= '0;
      op_msb      <= 1'b0;
      is_read     <= 1'b0;
      phyad       <= '0;
      regad       <= '0;
      shreg       <= '0;
      mdio_o      <= 1'b1;
      mdio_en     <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      frame_err   <= 1'b0;
      for (int i = 0; i < 32; i++) bank[i] <= '0;
      bank[2] <= PHY_ID1;
      bank[3] <= PHY_ID2;
    end else begin
      reg_wr_en <= 1'b0;
      frame_err <= 1'b0;
      if (mdc_rise) begin
        case (state)
          IDLE: begin
            if (mdio_s) begin
              if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
            end else begin
              // This 0 is the first start bit when the preamble is complete.
              if (pre_cnt == PRE_MAX) state <= ST;
              pre_cnt <= '0;
            end
          end
          ST: begin
            bit_cnt <= '0;
            state   <= mdio_s ? OP : IDLE;
          end
          OP: begin
            if (bit_cnt == 4'd0) begin
              op_msb  <= mdio_s;
              bit_cnt <= 4'd1;
            end else begin
              bit_cnt <= '0;
              // 10 = read, 01 = write; equal bits are invalid opcodes.
              if (op_msb != mdio_s) begin
                is_read <= op_msb;
                state   <= PHYAD;
              end else begin
                state <= IDLE;
              end
            end
          end
          PHYAD: begin
            phyad <= {phyad[3:0], mdio_s};
            if (bit_cnt == 4'd4) begin
              bit_cnt <= '0;
              state   <= REGAD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          REGAD: begin
            regad <= {regad[3:0], mdio_s};
            if (bit_cnt == 4'd4) begin
              bit_cnt <= '0;
              if (phyad != PHY_ADDR) begin
                state <= IDLE;
              end else begin
                state <= TA;
                // Snapshot so a later write cannot tear this read.
                shreg <= bank[{regad[3:0], mdio_s}];
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          TA: begin
            if (is_read) begin
              if (bit_cnt == 4'd0) begin
                mdio_en <= 1'b1;
                mdio_o  <= 1'b0;
                bit_cnt <= 4'd1;
              end else begin
                mdio_o  <= shreg[15];
                shreg   <= {shreg[14:0], 1'b0};
                bit_cnt <= '0;
                state   <= RDATA;
              end
            end else begin
              // Master must drive TA = 1 then 0 on a write.
              if (bit_cnt == 4'd0) begin
                if (!mdio_s) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
                end else begin
                  bit_cnt <= 4'd1;
                end
              end else begin
                bit_cnt <= '0;
                if (mdio_s) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          WDATA: begin
            shreg <= wr_word;
            if (bit_cnt == 4'd15) begin
              bit_cnt     <= '0;
              state       <= IDLE;
              reg_wr_en   <= 1'b1;
              reg_wr_addr <= regad;
              reg_wr_data <= wr_word;
              if (regad == 5'd0 && wr_word[15]) begin
                // Soft reset: reload defaults; reg0 default clears bit 15.
                for (int i = 0; i < 32; i++) bank[i] <= '0;
                bank[2] <= PHY_ID1;
                bank[3] <= PHY_ID2;
              end else if (regad != 5'd2 && regad != 5'd3) begin
                bank[regad] <= wr_word;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RDATA: begin
            if (bit_cnt == 4'd15) begin
              mdio_en <= 1'b0;
              mdio_o  <= 1'b1;
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              mdio_o  <= shreg[15];
              shreg   <= {shreg[14:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed testbench for mdio_phy_responder. The bench acts as the MDIO
// master: it drives MDIO while MDC is low, raises MDC, and samples the
// responder's outputs late in the MDC high phase.
module tb_mdio_phy_responder;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        mdc;
  logic        mdio_drv;
  logic        mdio_in;
  logic        mdio_o;
  logic        mdio_en;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        frame_err;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Pad model: the responder wins when it enables its driver.
  assign mdio_in = mdio_en ? mdio_o : mdio_drv;

  mdio_phy_responder #(
    .PHY_ADDR(5'd0), .PREAMBLE_LEN(32), .PHY_ID1(16'h0022), .PHY_ID2(16'h1622)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_o(mdio_o), .mdio_en(mdio_en), .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .frame_err(frame_err), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Event monitor: counts strobes and enabled-driver cycles.
  int          wr_cnt = 0;
  int          err_cnt = 0;
  int          en_cycles = 0;
  logic [4:0]  last_addr = '0;
  logic [15:0] last_data = '0;
  always @(posedge sys_clk) begin
    if (reg_wr_en) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = reg_wr_addr;
      last_data = reg_wr_data;
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (mdio_en) en_cycles = en_cycles + 1;
  end

  // Driver tasks
  logic s_en, s_o;

  task automatic mdc_cycle(input logic b);
    mdc = 1'b0;
    mdio_drv = b;
    #40;
    mdc = 1'b1;
    #36;
    s_en = mdio_en;
    s_o  = mdio_o;
    #4;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mdc_cycle(v[i]);
  endtask

  task automatic write_frame(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [1:0] ta, input logic [15:0] data);
    send_bits(32'hFFFF_FFFF, pre);
    send_bits(32'b0101, 4);
    send_bits({27'd0, phy}, 5);
    send_bits({27'd0, ra}, 5);
    send_bits({30'd0, ta}, 2);
    send_bits({16'd0, data}, 16);
  endtask

  // flags = {en after REGAD, en after TA1, o after TA1, en for all data, en after end}
  task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra,
                            output logic [15:0] data, output logic [4:0] flags);
    logic all_en;
    send_bits(32'hFFFF_FFFF, 32);
    send_bits(32'b0110, 4);
    send_bits({27'd0, phy}, 5);
    send_bits({27'd0, ra}, 5);
    flags[4] = s_en;
    mdc_cycle(1'b1);
    flags[3] = s_en;
    flags[2] = s_o;
    mdc_cycle(1'b1);
    data[15] = s_o;
    all_en = s_en;
    for (int i = 14; i >= 0; i--) begin
      mdc_cycle(1'b1);
      data[i] = s_o;
      all_en = all_en & s_en;
    end
    flags[1] = all_en;
    mdc_cycle(1'b1);
    flags[0] = s_en;
  endtask

  // Scenarios
  task automatic test_reset();
    sys_rst_n = 1'b0;
    mdc = 1'b1;
    mdio_drv = 1'b1;
    #23;
    n_checks++; if (mdio_o !== 1'b1) begin n_fail++; $display("FAIL reset_mdio_o got %b exp 1", mdio_o); end
    n_checks++; if (mdio_en !== 1'b0) begin n_fail++; $display("FAIL reset_mdio_en got %b exp 0", mdio_en); end
    n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b exp 0", reg_wr_en); end
    n_checks++; if (reg_wr_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wr_addr got %h exp 0", reg_wr_addr); end
    n_checks++; if (reg_wr_data !== 16'd0) begin n_fail++; $display("FAIL reset_wr_data got %h exp 0", reg_wr_data); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
    sys_rst_n = 1'b1;
    #30;
    @(negedge sys_clk);
  endtask

  task automatic test_write();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    write_frame(32, 5'd0, 5'd0, 2'b10, 16'h2100);
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL write_pulses got %0d exp 1", wr_cnt - w0); end
    n_checks++; if (last_addr !== 5'd0) begin n_fail++; $display("FAIL write_addr got %h exp 0", last_addr); end
    n_checks++; if (last_data !== 16'h2100) begin n_fail++; $display("FAIL write_data got %h exp 2100", last_data); end
    n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL write_frame_err got %0d exp 0", err_cnt - e0); end
  endtask

  task automatic test_readback();
    logic [15:0] d;
    logic [4:0]  f;
    read_frame(5'd0, 5'd0, d, f);
    n_checks++; if (d !== 16'h2100) begin n_fail++; $display("FAIL readback_data got %h exp 2100", d); end
    n_checks++; if (f !== 5'b01010) begin n_fail++; $display("FAIL readback_timing got %b exp 01010", f); end
  endtask

  task automatic test_id_protect();
    logic [15:0] d;
    logic [4:0]  f;
    int w0;
    read_frame(5'd0, 5'd2, d, f);
    n_checks++; if (d !== 16'h0022) begin n_fail++; $display("FAIL id1_read got %h exp 0022", d); end
    w0 = wr_cnt;
    write_frame(32, 5'd0, 5'd3, 2'b10, 16'hFFFF);
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL id2_write_pulse got %0d exp 1", wr_cnt - w0); end
    n_checks++; if (last_addr !== 5'd3) begin n_fail++; $display("FAIL id2_write_addr got %h exp 3", last_addr); end
    read_frame(5'd0, 5'd3, d, f);
    n_checks++; if (d !== 16'h1622) begin n_fail++; $display("FAIL id2_protect got %h exp 1622", d); end
  endtask

  task automatic test_addr_filter();
    int w0, c0;
    w0 = wr_cnt; c0 = en_cycles;
    write_frame(32, 5'd5, 5'd1, 2'b10, 16'h1234);
    n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL filter_write got %0d exp 0", wr_cnt - w0); end
    n_checks++; if (en_cycles - c0 !== 0) begin n_fail++; $display("FAIL filter_drive got %0d exp 0", en_cycles - c0); end
  endtask

  task automatic test_short_preamble_bad_ta();
    logic [15:0] d;
    logic [4:0]  f;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    write_frame(31, 5'd0, 5'd1, 2'b10, 16'h1234);
    n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL short_pre_write got %0d exp 0", wr_cnt - w0); end
    write_frame(32, 5'd0, 5'd1, 2'b11, 16'hBEEF);
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL bad_ta_err got %0d exp 1", err_cnt - e0); end
    n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL bad_ta_write got %0d exp 0", wr_cnt - w0); end
    read_frame(5'd0, 5'd1, d, f);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL bad_ta_bank got %h exp 0000", d); end
  endtask

  task automatic test_soft_reset();
    logic [15:0] d;
    logic [4:0]  f;
    write_frame(32, 5'd0, 5'd5, 2'b10, 16'h00AA);
    read_frame(5'd0, 5'd5, d, f);
    n_checks++; if (d !== 16'h00AA) begin n_fail++; $display("FAIL reg5_before got %h exp 00aa", d); end
    write_frame(32, 5'd0, 5'd0, 2'b10, 16'h8000);
    n_checks++; if (last_data !== 16'h8000) begin n_fail++; $display("FAIL soft_reset_data got %h exp 8000", last_data); end
    read_frame(5'd0, 5'd0, d, f);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL soft_reset_reg0 got %h exp 0000", d); end
    read_frame(5'd0, 5'd2, d, f);
    n_checks++; if (d !== 16'h0022) begin n_fail++; $display("FAIL soft_reset_reg2 got %h exp 0022", d); end
    read_frame(5'd0, 5'd5, d, f);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL soft_reset_reg5 got %h exp 0000", d); end
  endtask

  task automatic test_reset_mid_read();
    send_bits(32'hFFFF_FFFF, 32);
    send_bits(32'b0110, 4);
    send_bits(32'd0, 5);
    send_bits(32'd2, 5);
    mdc_cycle(1'b1);
    mdc_cycle(1'b1);
    // RDATA bits 14..8 presented; bit 8 is now on the wire.
    for (int i = 0; i < 7; i++) mdc_cycle(1'b1);
    n_checks++; if (s_en !== 1'b1) begin n_fail++; $display("FAIL mid_read_driving got %b exp 1", s_en); end
    sys_rst_n = 1'b0;
    #1;
    n_checks++; if (mdio_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_en got %b exp 0", mdio_en); end
    n_checks++; if (mdio_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_o got %b exp 1", mdio_o); end
    n_checks++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL mid_reset_state got %0d exp 0", fsm_state); end
    #40;
    sys_rst_n = 1'b1;
    #30;
    @(negedge sys_clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic [4:0]  f;
    int w0;
    w0 = wr_cnt;
    write_frame(32, 5'd0, 5'd4, 2'b10, 16'h5A5A);
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL post_reset_write got %0d exp 1", wr_cnt - w0); end
    n_checks++; if (last_addr !== 5'd4) begin n_fail++; $display("FAIL post_reset_addr got %h exp 4", last_addr); end
    read_frame(5'd0, 5'd4, d, f);
    n_checks++; if (d !== 16'h5A5A) begin n_fail++; $display("FAIL post_reset_read got %h exp 5a5a", d); end
    n_checks++; if (f !== 5'b01010) begin n_fail++; $display("FAIL post_reset_timing got %b exp 01010", f); end
    read_frame(5'd0, 5'd0, d, f);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL post_reset_reg0 got %h exp 0000", d); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_id_protect();
    test_addr_filter();
    test_short_preamble_bad_ta();
    test_soft_reset();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
